frame_assembler: RTL and testbench

Builds one binary LENGTH x WIDTH frame from a row-major 8-bit grayscale pixel stream and hands it to the gesture classifier. Each pixel is thresholded to one bit and written into a working buffer. On a well-formed frame, the buffer is copied to the registered `image` output and `init_out` is pulsed for one cycle to drive the classifier's `init_in`. The block then holds the frame until the downstream side acknowledges it.

---
 rtl/frame_assembler_pkg.sv | 21 ++
 rtl/frame_assembler_if.sv | 31 +++
 rtl/frame_coord_counter.sv | 53 +++++
 rtl/frame_assembler.sv | 168 ++++++++++++++++
 tb/tb_frame_assembler.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_assembler_pkg.sv
// rtl/frame_assembler_pkg.sv - shared frame geometry, pixel format and assembler state type
package frame_assembler_pkg;

    localparam int LENGTH    = 32;   // rows per frame
    localparam int WIDTH     = 32;   // pixels per row (at most 32)
    localparam int PIX_BITS  = 8;    // grayscale pixel width
    localparam int THRESHOLD = 128;  // pixel >= THRESHOLD becomes a 1 bit

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PUBLISH = 2'd2,
        HOLD    = 2'd3
    } asm_state_t;

    // Index width for a dimension of n entries; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_assembler_if.sv
// rtl/frame_assembler_if.sv - row-major pixel stream between a pixel source and the assembler
//   pix_valid : source offers a beat
//   pix_ready : sink accepts the beat this cycle
//   pix_data  : grayscale pixel
//   pix_sof   : beat is pixel (0,0)
//   pix_eof   : beat is the last pixel of the frame
interface frame_assembler_if #(
    parameter int PIX_BITS = frame_assembler_pkg::PIX_BITS
);
    logic                pix_valid;
    logic                pix_ready;
    logic [PIX_BITS-1:0] pix_data;
    logic                pix_sof;
    logic                pix_eof;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        output pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        input  pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/frame_coord_counter.sv
// rtl/frame_coord_counter.sv - row/col write position with clear, increment and wrap
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to (0,0); together with inc the result is the position after (0,0)
//   inc        : advance one pixel, col wraps into the next row
//   row, col   : current write position
//   at_last    : position is (LENGTH-1, WIDTH-1)
module frame_coord_counter #(
    parameter int LENGTH = frame_assembler_pkg::LENGTH,
    parameter int WIDTH  = frame_assembler_pkg::WIDTH,
    localparam int RW    = frame_assembler_pkg::idx_bits(LENGTH),
    localparam int CW    = frame_assembler_pkg::idx_bits(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_last
);
    import frame_assembler_pkg::*;

    logic [RW-1:0] base_row, row_nxt;
    logic [CW-1:0] base_col, col_nxt;

    assign at_last = (row == RW'(LENGTH - 1)) && (col == CW'(WIDTH - 1));

    always_comb begin
        base_row = clr ? '0 : row;
        base_col = clr ? '0 : col;
        row_nxt  = base_row;
        col_nxt  = base_col;
        if (inc) begin
            if (base_col == CW'(WIDTH - 1)) begin
                col_nxt = '0;
                row_nxt = (base_row == RW'(LENGTH - 1)) ? '0 : base_row + 1'b1;
            end else begin
                col_nxt = base_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// rtl/frame_assembler.sv - thresholds a pixel stream into a binary frame and publishes it to the classifier
//   clk, rst_n : clock, asynchronous active-low reset
//   pix        : pixel stream (slave side)
//   image      : published frame, image[row][col]
//   init_out   : one-cycle strobe while a new image is first presented
//   frame_ack  : downstream releases the published frame
//   busy       : a frame is being filled, published or held
//   err_count  : saturating protocol error count
module frame_assembler #(
    parameter int LENGTH    = frame_assembler_pkg::LENGTH,
    parameter int WIDTH     = frame_assembler_pkg::WIDTH,
    parameter int PIX_BITS  = frame_assembler_pkg::PIX_BITS,
    parameter int THRESHOLD = frame_assembler_pkg::THRESHOLD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    frame_assembler_if.slave             pix,
    output logic [LENGTH-1:0][WIDTH-1:0] image,
    output logic                         init_out,
    input  logic                         frame_ack,
    output logic                         busy,
    output logic [7:0]                   err_count
);
    import frame_assembler_pkg::*;

    localparam int RW = idx_bits(LENGTH);
    localparam int CW = idx_bits(WIDTH);
    // A one-pixel frame completes on its start-of-frame beat.
    localparam bit SINGLE = (LENGTH * WIDTH == 1);

    asm_state_t                  state, state_nxt;
    logic [LENGTH-1:0][WIDTH-1:0] work;
    logic [RW-1:0]               row;
    logic [CW-1:0]               col;
    logic                        at_last;
    logic                        ready, accept, pix_bit;
    logic [31:0]                 pix_wide;
    logic                        cnt_clr, cnt_inc, wr_en, wr_first, publish, err_inc;

    assign pix.pix_ready = ready;
    assign accept        = pix.pix_valid && ready;
    assign pix_wide      = 32'(pix.pix_data);
    assign pix_bit       = (pix_wide >= 32'(THRESHOLD));

    frame_coord_counter #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .row     (row),
        .col     (col),
        .at_last (at_last)
    );

    // ready/busy/init_out decode from the state register only, never from pix_valid.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b1;
        init_out  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        wr_en     = 1'b0;
        wr_first  = 1'b0;
        publish   = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (accept) begin
                    if (!pix.pix_sof) begin
                        err_inc = 1'b1;
                    end else if (SINGLE) begin
                        if (pix.pix_eof) begin
                            wr_en     = 1'b1;
                            publish   = 1'b1;
                            state_nxt = PUBLISH;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else begin
                        wr_en     = 1'b1;
                        wr_first  = 1'b1;
                        cnt_clr   = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                ready = 1'b1;
                if (accept) begin
                    if (pix.pix_sof) begin
                        // Restart: the partial frame is overwritten as the new one fills.
                        wr_en    = 1'b1;
                        wr_first = 1'b1;
                        cnt_clr  = 1'b1;
                        cnt_inc  = 1'b1;
                        err_inc  = 1'b1;
                    end else if (at_last && pix.pix_eof) begin
                        wr_en     = 1'b1;
                        publish   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = PUBLISH;
                    end else if (at_last || pix.pix_eof) begin
                        err_inc   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            PUBLISH: begin
                init_out  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (frame_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final pixel bypasses work so image carries it at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            image <= '0;
        end else begin
            if (wr_en) begin
                if (wr_first) begin
                    work[0][0] <= pix_bit;
                end else begin
                    work[row][col] <= pix_bit;
                end
            end
            if (publish) begin
                image           <= work;
                image[row][col] <= pix_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// tb/tb_frame_assembler.sv - scoreboard bench for frame_assembler
module tb_frame_assembler;
    localparam int L  = 32;
    localparam int W  = 32;
    localparam int PB = 8;
    localparam int TH = 128;
    localparam int LW = L * W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frame_assembler_if #(.PIX_BITS(PB)) pix_if ();
    logic [L-1:0][W-1:0] image;
    logic                init_out;
    logic                frame_ack;
    logic                busy;
    logic [7:0]          err_count;

    frame_assembler #(
        .LENGTH    (L),
        .WIDTH     (W),
        .PIX_BITS  (PB),
        .THRESHOLD (TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix       (pix_if),
        .image     (image),
        .init_out  (init_out),
        .frame_ack (frame_ack),
        .busy      (busy),
        .err_count (err_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [L-1:0][W-1:0] img;
        int                  cycle;
        int                  err;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a frame is a flat list of LW bits filled in stream order.
    bit                  m_in_frame = 0;
    bit                  m_held     = 0;
    int                  m_pos      = 0;
    int                  m_err      = 0;
    bit                  m_buf[LW];
    logic [L-1:0][W-1:0] m_last_img = '0;
    bit                  gaps       = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [L-1:0][W-1:0] act,
                           input logic [L-1:0][W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int r = 0; r < L; r++) begin
                if (act[r] !== exp[r]) begin
                    $display("FAIL %s: row %0d got %h expected %h", name, r, act[r], exp[r]);
                    break;
                end
            end
        end
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_publish(input int cycle);
        exp_t e;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++)
                e.img[r][c] = m_buf[r * W + c];
        e.cycle    = cycle + 1;
        e.err      = m_err;
        m_last_img = e.img;
        exp_q.push_back(e);
    endtask

    task automatic model_beat(input int data, input bit sof, input bit eof, input int cycle);
        bit b;
        b = (data >= TH);
        if (sof) begin
            if (m_in_frame) bump_err();
            m_buf[0]   = b;
            m_pos      = 1;
            m_in_frame = 1;
        end else if (!m_in_frame) begin
            bump_err();
        end else if (m_pos == LW - 1) begin
            m_in_frame = 0;
            if (eof) begin
                m_buf[m_pos] = b;
                m_held       = 1;
                model_publish(cycle);
            end else begin
                bump_err();
            end
        end else if (eof) begin
            bump_err();
            m_in_frame = 0;
        end else begin
            m_buf[m_pos] = b;
            m_pos++;
        end
    endtask

    function automatic int pix_for(input int pattern, input int r, input int c);
        if (pattern == 0) return (((r + c) % 2) == 0) ? 200 : 10;
        if (pattern == 2 && r == 0 && c == 0) return 127;
        if (pattern == 2 && r == 0 && c == 1) return 128;
        return int'($urandom_range(0, 255));
    endfunction

    task automatic drive_beat(input int data, input bit sof, input bit eof);
        if (gaps && $urandom_range(0, 7) == 0) begin
            @(negedge clk);
            pix_if.pix_valid = 1'b0;
        end
        @(negedge clk);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = PB'(data);
        pix_if.pix_sof   = sof;
        pix_if.pix_eof   = eof;
        model_beat(data, sof, eof, cyc);
    endtask

    task automatic send_beats(input int pattern, input int n, input int eof_idx);
        for (int i = 0; i < n; i++)
            drive_beat(pix_for(pattern, i / W, i % W), i == 0, i == eof_idx);
    endtask

    task automatic end_stream();
        @(negedge clk);
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof   = 1'b0;
        pix_if.pix_eof   = 1'b0;
    endtask

    task automatic wait_publish();
        end_stream();
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL publish_timeout: got no init_out, pending %0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        chk("hold_ready", pix_if.pix_ready, 0);
        chk("hold_busy", busy, 1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        m_held    = 0;
        chk("ack_ready", pix_if.pix_ready, 1);
        chk("ack_busy", busy, 0);
    endtask

    task automatic chk_state(input string name);
        chk({name, "_err"}, err_count, m_err);
        chk({name, "_busy"}, busy, (m_in_frame || m_held) ? 1 : 0);
    endtask

    // Monitor: every init_out pops one expected frame; image may only change on init_out.
    initial begin
        logic [L-1:0][W-1:0] prev_img;
        exp_t e;
        prev_img = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_img = '0;
            end else begin
                if (init_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_init: got init_out at cycle %0d expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk_img("image", image, e.img);
                        chk("init_cycle", cyc, e.cycle);
                        chk("publish_err", err_count, e.err);
                    end
                end
                if (image !== prev_img) begin
                    checks++;
                    if (!init_out) begin
                        errors++;
                        $display("FAIL image_stable: got change at cycle %0d expected change only with init_out", cyc);
                    end
                end
                prev_img = image;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, n;
        bool_blk: begin end
        rst_n            = 1'b0;
        frame_ack        = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = '0;
        pix_if.pix_sof   = 1'b0;
        pix_if.pix_eof   = 1'b0;
        #3;
        chk_img("rst_image", image, '0);
        chk("rst_init", init_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ready", pix_if.pix_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean checkerboard frame.
        send_beats(0, LW, LW - 1);
        wait_publish();
        chk("checker_00", image[0][0], 1);
        chk("checker_01", image[0][1], 0);
        chk("checker_err", err_count, 0);
        do_ack();

        // Threshold boundary, then a long hold with pix_valid offered.
        send_beats(2, LW, LW - 1);
        wait_publish();
        chk("thr_127", image[0][0], 0);
        chk("thr_128", image[0][1], 1);
        begin
            int ready_hi, img_chg;
            ready_hi = 0;
            img_chg  = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                pix_if.pix_valid = 1'b1;
                pix_if.pix_sof   = 1'b1;
                pix_if.pix_data  = PB'($urandom_range(0, 255));
                if (pix_if.pix_ready !== 1'b0) ready_hi++;
                if (image !== m_last_img) img_chg++;
            end
            pix_if.pix_valid = 1'b0;
            pix_if.pix_sof   = 1'b0;
            chk("hold20_ready_cycles", ready_hi, 0);
            chk("hold20_image_changes", img_chg, 0);
        end
        do_ack();

        // pix_sof at (3,5) restarts; the second frame is published.
        send_beats(1, 3 * W + 5, -1);
        send_beats(0, LW, LW - 1);
        wait_publish();
        chk("restart_err", err_count, 1);
        do_ack();

        // Early pix_eof at (10,0).
        send_beats(1, 10 * W + 1, 10 * W);
        end_stream();
        chk("early_eof_err", err_count, 2);
        chk_state("early_eof");

        // Missing pix_eof at the last position.
        send_beats(1, LW, -1);
        end_stream();
        chk("no_eof_err", err_count, 3);
        chk_state("no_eof");

        // Randomized frames with gaps and injected protocol errors.
        gaps = 1;
        for (int it = 0; it < 5; it++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: begin
                    send_beats(1, LW, LW - 1);
                    wait_publish();
                    do_ack();
                end
                1: begin
                    n = int'($urandom_range(1, LW - 2));
                    send_beats(1, n + 1, n);
                    end_stream();
                end
                2: begin
                    send_beats(1, int'($urandom_range(1, LW - 1)), -1);
                    send_beats(1, LW, LW - 1);
                    wait_publish();
                    do_ack();
                end
                default: begin
                    send_beats(1, LW, -1);
                    end_stream();
                end
            endcase
            chk_state("random");
        end
        gaps = 0;

        // Saturation: stray beats in IDLE.
        for (int i = 0; i < 260; i++)
            drive_beat(int'($urandom_range(0, 255)), 1'b0, 1'b0);
        end_stream();
        chk("err_saturated", err_count, 255);
        chk_state("saturate");

        // Asynchronous reset mid-frame at (7,7).
        send_beats(1, 7 * W + 7, -1);
        end_stream();
        #2;
        rst_n = 1'b0;
        #1;
        chk_img("midrst_image", image, '0);
        chk("midrst_init", init_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_ready", pix_if.pix_ready, 1);
        m_err      = 0;
        m_in_frame = 0;
        m_held     = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        send_beats(0, LW, LW - 1);
        wait_publish();
        do_ack();
        chk("final_err", err_count, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
